// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared types and default widths for the two-client video RAM.
//   host_state_e : host read FSM states (IDLE, PEND, DONE)
//   VRAM_*       : default data width, address width and depth
// -----------------------------------------------------------------------------
package vram_pkg;

   localparam int VRAM_DATA_W = 8;
   localparam int VRAM_ADDR_W = 13;
   localparam int VRAM_DEPTH  = 8192;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      DONE = 2'd2
   } host_state_e;

endpackage

// File: rtl/vram_bram.sv
// -----------------------------------------------------------------------------
// vram_bram
// Storage for the video RAM: one write port and one registered read port,
// shaped so the memory maps onto ICE40 block RAM.
// Addresses at or above DEPTH are out of range. Writes to them are dropped,
// and reads from them return 0.
// A read and a write to the same address in one cycle return the old word.
// The memory has no reset, so writes are also accepted while the rest of the
// design is in reset.
// Ports:
//   clk      : system clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, a new read is taken every cycle
//   rd_data  : read result, one cycle after rd_addr
// -----------------------------------------------------------------------------
module vram_bram
   import vram_pkg::*;
#(
   parameter int DATA_W    = VRAM_DATA_W,
   parameter int ADDR_W    = VRAM_ADDR_W,
   parameter int DEPTH     = VRAM_DEPTH,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] rd_word_q;
   logic              rd_oob_q, rd_oob_d;
   logic              wr_in_range;

   // One extra bit lets DEPTH == 2**ADDR_W be compared without overflowing.
   assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

   always_comb begin
      rd_oob_d = ({1'b0, rd_addr} >= (ADDR_W+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   // The out-of-range mask is applied after the data register. Because of
   // that, the memory itself stays a plain registered-read block RAM.
   always_ff @(posedge clk) begin
      rd_word_q <= mem[rd_addr[IDX_W-1:0]];
      rd_oob_q  <= rd_oob_d;
   end

   assign rd_data = rd_oob_q ? '0 : rd_word_q;

endmodule

// File: rtl/vram_arb.sv
// -----------------------------------------------------------------------------
// vram_arb
// Video RAM with one host write port and two read clients that share the
// single block-RAM read port. The display fetch client has priority and fixed
// 1-cycle latency. The host read client uses a req/ack handshake and is served
// in cycles that the display leaves idle.
// Optional feature (macro VRAM_HOST_STARVE_EN): after STARVE_LIMIT blocked
// cycles, a pending host read takes the port. The display read in that cycle
// is dropped and flagged on dispRdMiss.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   wr, wrAddr, wrData              : host write port
//   dispRdEn, dispRdAddr            : display read request
//   dispRdData, dispRdValid         : display read result (1 cycle later)
//   dispRdMiss                      : display read dropped (feature only)
//   hostRdReq, hostRdAddr           : host read request
//   hostRdBusy, hostRdAck, hostRdData : host read handshake and result
//
// state | meaning
// IDLE  | no host read outstanding; a request is accepted here
// PEND  | host address latched, waiting for a free read port
// DONE  | host read result on the RAM output; ack pulses
// -----------------------------------------------------------------------------
module vram_arb
   import vram_pkg::*;
#(
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DEPTH        = VRAM_DEPTH,
   parameter     INIT_FILE    = "",
   parameter int STARVE_LIMIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              wr,
   input  logic              dispRdEn,
   input  logic [ADDR_W-1:0] dispRdAddr,
   output logic [DATA_W-1:0] dispRdData,
   output logic              dispRdValid,
   output logic              dispRdMiss,
   input  logic              hostRdReq,
   input  logic [ADDR_W-1:0] hostRdAddr,
   output logic              hostRdBusy,
   output logic              hostRdAck,
   output logic [DATA_W-1:0] hostRdData
);

   generate
      if (DEPTH > (1 << ADDR_W) || STARVE_LIMIT < 0) begin : g_bad_params
         $error("vram_arb: DEPTH must fit in ADDR_W and STARVE_LIMIT must be >= 0");
      end
   endgenerate

   host_state_e       state_q, state_d;
   logic [ADDR_W-1:0] host_addr_q, host_addr_d;
   logic              busy_q, busy_d;
   logic              ack_q, ack_d;
   logic [DATA_W-1:0] host_data_q, host_data_d;
   logic              disp_valid_q, disp_valid_d;
   logic              disp_miss_q, disp_miss_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;

   logic              force_issue;
   logic              host_issue;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

`ifdef VRAM_HOST_STARVE_EN
   localparam int               CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign force_issue = (state_q == PEND) && (starve_cnt_q == CNT_MAX);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == IDLE) begin
         starve_cnt_d = '0;
      end else if (state_q == PEND && dispRdEn && starve_cnt_q != CNT_MAX) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign force_issue = 1'b0;
`endif

   assign host_issue = (state_q == PEND) && (!dispRdEn || force_issue);
   assign rd_addr    = host_issue ? host_addr_q : dispRdAddr;

   vram_bram #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_bram (
      .clk     (clk),
      .wr_en   (wr),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      host_addr_d  = host_addr_q;
      disp_valid_d = dispRdEn && !host_issue;
      disp_miss_d  = dispRdEn && force_issue;
      // The RAM output is only meaningful in the cycle after a read. These
      // registers keep the last result for each client.
      disp_data_d  = disp_valid_q ? rd_data : disp_data_q;
      host_data_d  = ack_q ? rd_data : host_data_q;

      case (state_q)
         IDLE: begin
            if (hostRdReq) begin
               host_addr_d = hostRdAddr;
               state_d     = PEND;
            end
         end
         PEND: begin
            if (host_issue) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == PEND);
      ack_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         host_addr_q  <= '0;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         host_data_q  <= '0;
         disp_valid_q <= 1'b0;
         disp_miss_q  <= 1'b0;
         disp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         host_addr_q  <= host_addr_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
         host_data_q  <= host_data_d;
         disp_valid_q <= disp_valid_d;
         disp_miss_q  <= disp_miss_d;
         disp_data_q  <= disp_data_d;
      end
   end

   assign dispRdData  = disp_valid_q ? rd_data : disp_data_q;
   assign dispRdValid = disp_valid_q;
   assign dispRdMiss  = disp_miss_q;
   assign hostRdBusy  = busy_q;
   assign hostRdAck   = ack_q;
   assign hostRdData  = ack_q ? rd_data : host_data_q;

endmodule
